lsu_mem_port: RTL and testbench

- Initiator side of the data-memory interface.
- Accepts one load/store op at a time from the OoO issue stage and computes the effective address.
- Drives word-addressed read/write requests with byte strobes into the data memory, waits the fixed memory read latency, and aligns and extends load data.
- Returns a tagged result to the writeback/CDB stage over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu_mem_port.sv | 156 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory port.
// State encoding, RISC-V funct3 size codes and a size legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic size_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: size_legal = 1'b1;
      default:                        size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and lane replication,
// load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_sh;

  assign w_sh = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_f3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      F3_H: begin
        o_wstrb = 4'b0011 << i_st_off;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ldata = i_rdata;
    case (i_ld_f3)
      F3_B:  o_ldata = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_BU: o_ldata = {24'd0, w_sh[7:0]};
      F3_H:  o_ldata = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_HU: o_ldata = {16'd0, w_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Data-memory initiator: one op in flight, fixed read latency.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W instead of aligning down.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_base_i,
  input  logic [DATA_WIDTH-1:0] req_imm_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_wstrb_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [TAG_WIDTH-1:0]  resp_tag_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_store_o,
  output logic                  resp_exc_o
);

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [3:0]            r_wstrb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic                  r_store;
  logic                  r_exc;

  logic [ADDR_WIDTH-1:0] w_ea;
  logic [1:0]            w_off;
  logic                  w_legal;
  logic                  w_mis;
  logic                  w_exc;
  logic                  w_accept;
  logic                  w_last;
  logic [3:0]            w_wstrb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ldata;

  assign w_ea    = ADDR_WIDTH'(req_base_i + req_imm_i);
  assign w_legal = size_legal(req_funct3_i);
  assign w_mis   = (req_funct3_i[1:0] == 2'b01 && w_ea[0]) ||
                   (req_funct3_i[1:0] == 2'b10 && w_ea[1:0] != 2'b00);
  assign w_accept = req_valid_i && req_ready_o;
  assign w_last   = (r_cnt == 3'd1);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_exc = !w_legal || w_mis;
  assign w_off = w_ea[1:0];
`else
  assign w_exc = !w_legal;
  // Misaligned halves/words are silently aligned down.
  assign w_off = (req_funct3_i[1:0] == 2'b01) ? {w_ea[1], 1'b0} :
                 (req_funct3_i[1:0] == 2'b10) ? 2'b00 : w_ea[1:0];
`endif

  lsu_align u_align (
    .i_st_f3   (req_funct3_i),
    .i_st_off  (w_off),
    .i_st_data (req_wdata_i),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .i_ld_f3   (r_f3),
    .i_ld_off  (r_off),
    .i_rdata   (mem_rdata_i),
    .o_ldata   (w_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_tag   <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_store <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= w_ea[ADDR_WIDTH-1:2];
        r_wstrb <= w_wstrb;
        r_wdata <= w_wdata;
        r_data  <= '0;
        r_tag   <= req_tag_i;
        r_f3    <= req_funct3_i;
        r_off   <= w_off;
        r_store <= req_store_i;
        r_exc   <= w_exc;
      end
      if (r_state == ISSUE && !r_store) r_cnt <= 3'(MEM_LATENCY);
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (w_last) r_data <= w_ldata;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready_o  = 1'b0;
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_wstrb_o  = 4'b0000;
    resp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_next = w_exc ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_we_o    = r_store;
        mem_re_o    = !r_store;
        mem_wstrb_o = r_store ? r_wstrb : 4'b0000;
        w_next      = r_store ? RESP : WAIT;
      end
      WAIT: if (w_last) w_next = RESP;
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign resp_tag_o   = r_tag;
  assign resp_data_o  = r_data;
  assign resp_store_o = r_store;
  assign resp_exc_o   = r_exc;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 3-cycle memory model.
// Expected values are hand-computed per scenario.
module tb_lsu_mem_port;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_base_i = '0;
  logic [31:0] req_imm_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [5:0]  req_tag_i = '0;
  logic [29:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [5:0]  resp_tag_o;
  logic [31:0] resp_data_o;
  logic        resp_store_o;
  logic        resp_exc_o;

  int checks = 0;
  int errors = 0;

  logic [31:0]    mem_word = '0;
  logic [LAT-1:0] rd_pipe = '0;
  int             we_cnt = 0;
  int             re_cnt = 0;
  logic [29:0]    st_addr = '0;
  logic [3:0]     st_strb = '0;
  logic [31:0]    st_data = '0;
  logic [29:0]    rd_addr = '0;

  int lat;
  int d_we;
  int d_re;

  always #5 clk = ~clk;

  lsu_mem_port #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .TAG_WIDTH  (6),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_store_i (req_store_i),
    .req_funct3_i(req_funct3_i),
    .req_base_i  (req_base_i),
    .req_imm_i   (req_imm_i),
    .req_wdata_i (req_wdata_i),
    .req_tag_i   (req_tag_i),
    .mem_addr_o  (mem_addr_o),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_tag_o  (resp_tag_o),
    .resp_data_o (resp_data_o),
    .resp_store_o(resp_store_o),
    .resp_exc_o  (resp_exc_o)
  );

  // Read data is only meaningful exactly LAT cycles after the strobe.
  assign mem_rdata_i = rd_pipe[LAT-1] ? mem_word : 32'h5A5A5A5A;

  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[LAT-2:0], mem_re_o};
    if (mem_we_o) begin
      we_cnt  = we_cnt + 1;
      st_addr = mem_addr_o;
      st_strb = mem_wstrb_o;
      st_data = mem_wdata_o;
    end
    if (mem_re_o) begin
      re_cnt  = re_cnt + 1;
      rd_addr = mem_addr_o;
    end
  end

  task automatic run_op(input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] wd, input logic [5:0] tag,
                        input logic [31:0] rword);
    int we0;
    int re0;
    bit done;
    we0 = we_cnt;
    re0 = re_cnt;
    mem_word     = rword;
    req_store_i  = st;
    req_funct3_i = f3;
    req_base_i   = base;
    req_imm_i    = imm;
    req_wdata_i  = wd;
    req_tag_i    = tag;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    lat  = -1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (resp_valid_o) begin
        lat  = i;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    d_we = we_cnt - we0;
    d_re = re_cnt - re0;
  endtask

  task automatic ack;
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b exp 1", req_ready_o);
    end
    checks++;
    if ({resp_valid_o, mem_re_o, mem_we_o, resp_exc_o, resp_store_o} !== 5'b0) begin
      errors++;
      $display("FAIL rst_ctrl got %b exp 00000",
               {resp_valid_o, mem_re_o, mem_we_o, resp_exc_o, resp_store_o});
    end
    checks++;
    if ({mem_addr_o, mem_wstrb_o, mem_wdata_o, resp_data_o, resp_tag_o} !== '0) begin
      errors++;
      $display("FAIL rst_data got %h %h %h %h %h exp 0", mem_addr_o,
               mem_wstrb_o, mem_wdata_o, resp_data_o, resp_tag_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sw;
    run_op(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 6'd5, 32'h0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sw_lat got %0d exp 1", lat); end
    checks++;
    if (d_we !== 1 || d_re !== 0) begin
      errors++; $display("FAIL sw_strobes got we=%0d re=%0d exp 1/0", d_we, d_re);
    end
    checks++;
    if ({st_addr, st_strb, st_data} !== {30'h41, 4'b1111, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_bus got %h %b %h exp 41 1111 deadbeef", st_addr, st_strb, st_data);
    end
    checks++;
    if ({resp_store_o, resp_exc_o, resp_tag_o, resp_data_o} !== {1'b1, 1'b0, 6'd5, 32'h0}) begin
      errors++;
      $display("FAIL sw_resp got st=%b exc=%b tag=%h d=%h exp 1 0 05 0",
               resp_store_o, resp_exc_o, resp_tag_o, resp_data_o);
    end
    ack();
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL sw_ack got v=%b r=%b exp 0 1", resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_sb_lb;
    run_op(1'b1, 3'b000, 32'h200, 32'h3, 32'h00000080, 6'd1, 32'h0);
    checks++;
    if ({st_addr, st_strb, st_data} !== {30'h80, 4'b1000, 32'h80808080} || d_we !== 1) begin
      errors++;
      $display("FAIL sb_bus got %h %b %h n=%0d exp 80 1000 80808080 1",
               st_addr, st_strb, st_data, d_we);
    end
    ack();
    run_op(1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 6'd2, 32'h80123456);
    checks++;
    if (lat !== LAT + 1 || d_re !== 1 || rd_addr !== 30'h80 || d_we !== 0) begin
      errors++;
      $display("FAIL lb_timing got lat=%0d re=%0d we=%0d a=%h exp %0d 1 0 80",
               lat, d_re, d_we, rd_addr, LAT + 1);
    end
    checks++;
    if (resp_data_o !== 32'hFFFFFF80 || resp_store_o !== 1'b0) begin
      errors++;
      $display("FAIL lb_data got %h st=%b exp ffffff80 0", resp_data_o, resp_store_o);
    end
    ack();
    run_op(1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 6'd3, 32'h80123456);
    checks++;
    if (resp_data_o !== 32'h00000080) begin
      errors++; $display("FAIL lbu_data got %h exp 00000080", resp_data_o);
    end
    ack();
  endtask

  task automatic test_lh;
    run_op(1'b0, 3'b001, 32'h10, 32'h2, 32'h0, 6'd7, 32'h80011234);
    checks++;
    if (lat !== LAT + 1 || d_re !== 1 || rd_addr !== 30'h4) begin
      errors++;
      $display("FAIL lh_timing got lat=%0d re=%0d a=%h exp %0d 1 4", lat, d_re, rd_addr, LAT + 1);
    end
    checks++;
    if (resp_data_o !== 32'hFFFF8001 || resp_tag_o !== 6'd7) begin
      errors++;
      $display("FAIL lh_data got %h tag=%h exp ffff8001 07", resp_data_o, resp_tag_o);
    end
    ack();
    run_op(1'b0, 3'b101, 32'h10, 32'h2, 32'h0, 6'd8, 32'h80011234);
    checks++;
    if (resp_data_o !== 32'h00008001) begin
      errors++; $display("FAIL lhu_data got %h exp 00008001", resp_data_o);
    end
    ack();
    run_op(1'b0, 3'b001, 32'h20, 32'hFFFFFFFE, 32'h0, 6'd9, 32'h7FFF0000);
    checks++;
    if (resp_data_o !== 32'h00007FFF || rd_addr !== 30'h7) begin
      errors++;
      $display("FAIL lh_negimm got %h a=%h exp 00007fff 7", resp_data_o, rd_addr);
    end
    ack();
  endtask

  task automatic test_backpressure;
    int we0;
    int re0;
    bit bad;
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 6'd33, 32'h12345678);
    we0 = we_cnt;
    re0 = re_cnt;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0 ||
          resp_tag_o !== 6'd33 || resp_data_o !== 32'h12345678) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_stable got v=%b r=%b tag=%h d=%h exp 1 0 21 12345678",
               resp_valid_o, req_ready_o, resp_tag_o, resp_data_o);
    end
    checks++;
    if (we_cnt !== we0 || re_cnt !== re0) begin
      errors++;
      $display("FAIL bp_nostrobe got we=%0d re=%0d exp 0 0", we_cnt - we0, re_cnt - re0);
    end
    ack();
  endtask

  task automatic test_misalign;
    run_op(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 6'd12, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (lat !== 0 || d_re !== 0 || resp_exc_o !== 1'b1 || resp_data_o !== 32'h0) begin
      errors++;
      $display("FAIL lw_mis got lat=%0d re=%0d exc=%b d=%h exp 0 0 1 0",
               lat, d_re, resp_exc_o, resp_data_o);
    end
`else
    checks++;
    if (lat !== LAT + 1 || d_re !== 1 || rd_addr !== 30'h40 || resp_exc_o !== 1'b0) begin
      errors++;
      $display("FAIL lw_mis got lat=%0d re=%0d a=%h exc=%b exp %0d 1 40 0",
               lat, d_re, rd_addr, resp_exc_o, LAT + 1);
    end
    checks++;
    if (resp_data_o !== 32'hCAFEF00D) begin
      errors++; $display("FAIL lw_mis_data got %h exp cafef00d", resp_data_o);
    end
`endif
    ack();
    run_op(1'b1, 3'b001, 32'h0, 32'h41, 32'h1234ABCD, 6'd13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (lat !== 0 || d_we !== 0 || resp_exc_o !== 1'b1) begin
      errors++;
      $display("FAIL sh_mis got lat=%0d we=%0d exc=%b exp 0 0 1", lat, d_we, resp_exc_o);
    end
`else
    checks++;
    if (d_we !== 1 || {st_addr, st_strb, st_data} !== {30'h10, 4'b0011, 32'hABCDABCD}) begin
      errors++;
      $display("FAIL sh_mis got we=%0d %h %b %h exp 1 10 0011 abcdabcd",
               d_we, st_addr, st_strb, st_data);
    end
`endif
    ack();
  endtask

  task automatic test_illegal;
    run_op(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 6'd20, 32'h11111111);
    checks++;
    if (lat !== 0 || d_re !== 0 || d_we !== 0 ||
        resp_exc_o !== 1'b1 || resp_data_o !== 32'h0) begin
      errors++;
      $display("FAIL illegal got lat=%0d re=%0d we=%0d exc=%b d=%h exp 0 0 0 1 0",
               lat, d_re, d_we, resp_exc_o, resp_data_o);
    end
    ack();
  endtask

  task automatic test_reset_mid;
    int re0;
    bit seen;
    re0 = re_cnt;
    mem_word     = 32'h87654321;
    req_store_i  = 1'b0;
    req_funct3_i = 3'b010;
    req_base_i   = 32'h500;
    req_imm_i    = 32'h0;
    req_tag_i    = 6'd40;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || mem_re_o !== 1'b0 ||
        resp_tag_o !== 6'd0 || mem_addr_o !== 30'h0) begin
      errors++;
      $display("FAIL rstmid_clr got r=%b v=%b re=%b tag=%h a=%h exp 1 0 0 0 0",
               req_ready_o, resp_valid_o, mem_re_o, resp_tag_o, mem_addr_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || re_cnt - re0 !== 1) begin
      errors++;
      $display("FAIL rstmid_idle got spurious=%b re=%0d exp 0 1", seen, re_cnt - re0);
    end
  endtask

  task automatic test_back_to_back;
    run_op(1'b1, 3'b001, 32'h600, 32'h2, 32'h0000BEEF, 6'd50, 32'h0);
    ack();
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_ready got %b exp 1", req_ready_o);
    end
    run_op(1'b0, 3'b000, 32'h600, 32'h1, 32'h0, 6'd51, 32'hAABB7FCC);
    checks++;
    if ({st_addr, st_strb, st_data} !== {30'h180, 4'b1100, 32'hBEEFBEEF} ||
        resp_data_o !== 32'h0000007F || resp_tag_o !== 6'd51) begin
      errors++;
      $display("FAIL b2b got %h %b %h d=%h tag=%h exp 180 1100 beefbeef 7f 33",
               st_addr, st_strb, st_data, resp_data_o, resp_tag_o);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_lb();
    test_lh();
    test_backpressure();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
